div_stream_collector: RTL and testbench

DIV_STREAM_COLLECTOR -- requirements
Module: div_stream_collector

---
 rtl/div_stream_collector.sv | 111 +++++++++++
 tb/tb_div_stream_collector.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_stream_collector.sv
// Credit-based collector for a fixed-latency, non-stallable divider: tracks issued
// operations, captures quotients into a result FIFO. Optional macro: DIV_ZERO_FLAG_EN.
module div_stream_collector #(
  parameter int DATA_LEN   = 32,
  parameter int TAG_LEN    = 8,
  parameter int LATENCY    = 11,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] in_a,
  input  logic [DATA_LEN-1:0] in_b,
  input  logic [TAG_LEN-1:0]  in_tag,
  output logic [DATA_LEN-1:0] div_a,
  output logic [DATA_LEN-1:0] div_b,
  input  logic [DATA_LEN-1:0] div_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] out_result,
  output logic [TAG_LEN-1:0]  out_tag
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic                out_dbz
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic                accept;
  logic                pop;
  logic                wr_en;
  logic [DATA_LEN-1:0] wr_data;

  logic [LATENCY-1:0]  vld_q, vld_d;
  logic [TAG_LEN-1:0]  tag_q [LATENCY];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       inflight_q, inflight_d;

  logic [DATA_LEN-1:0] res_mem [FIFO_DEPTH];
  logic [TAG_LEN-1:0]  tag_mem [FIFO_DEPTH];

  assign div_a = in_a;
  assign div_b = in_b;

  // Credits are implicit: a slot is free while queued plus in-flight results stay below depth.
  assign in_ready  = (count_q + inflight_q) != CW'(FIFO_DEPTH);
  assign out_valid = count_q != '0;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign wr_en     = vld_q[LATENCY-1];

`ifdef DIV_ZERO_FLAG_EN
  logic [LATENCY-1:0]    dbz_q;
  logic [FIFO_DEPTH-1:0] dbz_mem;

  assign wr_data = dbz_q[LATENCY-1] ? '1 : div_result;
  assign out_dbz = out_valid ? dbz_mem[rd_ptr_q] : 1'b0;

  always_ff @(posedge clk) begin
    dbz_q <= {dbz_q[LATENCY-2:0], (in_b == '0)};
    if (wr_en) dbz_mem[wr_ptr_q] <= dbz_q[LATENCY-1];
  end
`else
  assign wr_data = div_result;
`endif

  // Head of FIFO is forced to zero when empty so the outputs read 0 out of reset.
  assign out_result = out_valid ? res_mem[rd_ptr_q] : '0;
  assign out_tag    = out_valid ? tag_mem[rd_ptr_q] : '0;

  always_comb begin
    vld_d      = {vld_q[LATENCY-2:0], accept};
    wr_ptr_d   = wr_ptr_q + PW'(wr_en);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    count_d    = count_q + CW'(wr_en) - CW'(pop);
    inflight_d = inflight_q + CW'(accept) - CW'(wr_en);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
    end else begin
      vld_q      <= vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end

  // NOTE: tag pipeline and FIFO storage carry no reset; the valid bits and counters
  // alone decide what is live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    tag_q[0] <= in_tag;
    for (int k = 1; k < LATENCY; k++) tag_q[k] <= tag_q[k-1];
    if (wr_en) begin
      res_mem[wr_ptr_q] <= wr_data;
      tag_mem[wr_ptr_q] <= tag_q[LATENCY-1];
    end
  end

endmodule

// File: tb/tb_div_stream_collector.sv
// Self-checking bench for div_stream_collector: behavioural divider plus a queue-based
// timestamp model of issued, in-flight and queued results.
module tb_div_stream_collector;

  localparam int DATA_LEN   = 32;
  localparam int TAG_LEN    = 8;
  localparam int LATENCY    = 11;
  localparam int FIFO_DEPTH = 16;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [DATA_LEN-1:0] in_a = '0;
  logic [DATA_LEN-1:0] in_b = '0;
  logic [TAG_LEN-1:0]  in_tag = '0;
  logic [DATA_LEN-1:0] div_a, div_b, div_result;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [DATA_LEN-1:0] out_result;
  logic [TAG_LEN-1:0]  out_tag;
`ifdef DIV_ZERO_FLAG_EN
  logic                out_dbz;
`endif

  div_stream_collector #(
    .DATA_LEN(DATA_LEN), .TAG_LEN(TAG_LEN), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .div_a(div_a), .div_b(div_b), .div_result(div_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
`ifdef DIV_ZERO_FLAG_EN
    , .out_dbz(out_dbz)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_LEN-1:0] quot(input logic [DATA_LEN-1:0] a,
                                               input logic [DATA_LEN-1:0] b);
    if (b == '0) return '0;
    if (a == {1'b1, {(DATA_LEN-1){1'b0}}} && b == '1) return a;
    return $signed(a) / $signed(b);
  endfunction

  // Divider stand-in: operands sampled at an edge appear LATENCY cycles later.
  logic [DATA_LEN-1:0] pipe [LATENCY];
  always @(posedge clk) begin
    pipe[0] <= quot(div_a, div_b);
    for (int k = 1; k < LATENCY; k++) pipe[k] <= pipe[k-1];
  end
  assign div_result = pipe[LATENCY-1];

  typedef struct {
    logic [DATA_LEN-1:0] res;
    logic [TAG_LEN-1:0]  tag;
    logic                dbz;
    int                  due;
  } entry_t;

  entry_t fifo_m[$];
  entry_t fly_m[$];
  int     cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  logic   last_acc;
  logic   last_dut_ready;
  logic [TAG_LEN-1:0] obs_tags[$];
  int     obs_cyc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: compare outputs with the model, drive inputs, advance model past the edge.
  task automatic step(input logic v, input logic [DATA_LEN-1:0] a, input logic [DATA_LEN-1:0] b,
                      input logic [TAG_LEN-1:0] t, input logic ordy);
    logic   m_ready, m_valid, pop;
    entry_t e;
    m_ready = (fifo_m.size() + fly_m.size()) < FIFO_DEPTH;
    m_valid = fifo_m.size() != 0;
    check("in_ready", in_ready, m_ready);
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("out_result", out_result, fifo_m[0].res);
      check("out_tag", out_tag, fifo_m[0].tag);
`ifdef DIV_ZERO_FLAG_EN
      check("out_dbz", out_dbz, fifo_m[0].dbz);
`endif
    end
    last_dut_ready = in_ready;
    if (out_valid && ordy) begin
      obs_tags.push_back(out_tag);
      obs_cyc.push_back(cyc);
    end
    in_valid = v; in_a = a; in_b = b; in_tag = t; out_ready = ordy;
    last_acc = v && m_ready;
    pop = ordy && m_valid;
    e.tag = t;
    e.due = cyc + 1 + LATENCY;
`ifdef DIV_ZERO_FLAG_EN
    e.dbz = (b == '0);
    e.res = (b == '0) ? '1 : quot(a, b);
`else
    e.dbz = 1'b0;
    e.res = quot(a, b);
`endif
    @(posedge clk);
    cyc++;
    if (pop) void'(fifo_m.pop_front());
    if (fly_m.size() != 0 && fly_m[0].due == cyc) fifo_m.push_back(fly_m.pop_front());
    if (last_acc) fly_m.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 32'd1, '0, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    fifo_m.delete(); fly_m.delete();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_result", out_result, '0);
    check("rst_out_tag", out_tag, '0);
  endtask

  // Issue one operation into an empty pipeline and measure when the result shows up.
  task automatic single_op(input logic [DATA_LEN-1:0] a, input logic [DATA_LEN-1:0] b,
                           input logic [TAG_LEN-1:0] t, output int lat,
                           output logic [DATA_LEN-1:0] res, output logic [TAG_LEN-1:0] tg,
                           output logic dbz);
    lat = 0; res = '0; tg = '0; dbz = 1'b0;
    step(1'b1, a, b, t, 1'b1);
    for (int i = 1; i <= 30; i++) begin
      if (out_valid && lat == 0) begin
        lat = i; res = out_result; tg = out_tag;
`ifdef DIV_ZERO_FLAG_EN
        dbz = out_dbz;
`endif
      end
      step(1'b0, '0, 32'd1, '0, 1'b1);
    end
  endtask

  initial begin
    int                  lat, dut_acc, nxt, cyc0, seen;
    logic [DATA_LEN-1:0] res;
    logic [TAG_LEN-1:0]  tg;
    logic                dbz;
    logic [DATA_LEN-1:0] ra, rb;

    @(negedge clk);
    do_reset();

    single_op(32'd100, 32'd7, 8'h05, lat, res, tg, dbz);
    check("lat_first", lat, 12);
    check("res_100_7", res, 32'd14);
    check("tag_100_7", tg, 8'h05);

    single_op(-32'sd100, 32'd7, 8'h06, lat, res, tg, dbz);
    check("res_m100_7", res, 32'hFFFF_FFF2);
    check("tag_m100_7", tg, 8'h06);

    // Stall downstream: exactly FIFO_DEPTH accepts, then backpressure.
    dut_acc = 0; nxt = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, $urandom, ($urandom | 32'd1), TAG_LEN'(nxt), 1'b0);
      if (last_dut_ready) dut_acc++;
      if (last_acc) nxt++;
    end
    check("stall_accepts", dut_acc, FIFO_DEPTH);
    check("stall_in_ready", in_ready, 1'b0);
    obs_tags.delete(); obs_cyc.delete();
    step(1'b0, '0, 32'd1, '0, 1'b1);
    check("ready_after_pop", in_ready, 1'b1);
    idle(20);
    check("stall_drain_cnt", obs_tags.size(), FIFO_DEPTH);
    for (int i = 0; i < obs_tags.size(); i++) check("stall_order", obs_tags[i], TAG_LEN'(i));

    // Streaming at full rate: 100 tags, one result per cycle.
    obs_tags.delete(); obs_cyc.delete();
    cyc0 = cyc; nxt = 0;
    for (int i = 0; i < 140; i++) begin
      step(nxt < 100, $urandom, ($urandom | 32'd1), TAG_LEN'(nxt), 1'b1);
      if (last_acc) nxt++;
    end
    check("stream_cnt", obs_tags.size(), 100);
    if (obs_tags.size() == 100) begin
      check("stream_first", obs_cyc[0] - cyc0, 12);
      check("stream_span", obs_cyc[99] - obs_cyc[0], 99);
      for (int i = 0; i < 100; i++) check("stream_order", obs_tags[i], TAG_LEN'(i));
    end

    // Random traffic with random backpressure.
    for (int i = 0; i < 600; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? DATA_LEN'($urandom_range(1, 9)) : $urandom;
      if (rb == '0) rb = 32'd3;
      step($urandom_range(0, 3) != 0, ra, rb, TAG_LEN'($urandom), $urandom_range(0, 2) != 0);
    end
    idle(30);

    // Reset with 3 results queued and 5 still inside the divider.
    for (int i = 0; i < 3; i++) step(1'b1, 32'd50, 32'd5, TAG_LEN'(8'hA0 + i), 1'b0);
    for (int i = 0; i < LATENCY + 1; i++) step(1'b0, '0, 32'd1, '0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 32'd60, 32'd6, TAG_LEN'(8'hB0 + i), 1'b0);
    check("pre_reset_valid", out_valid, 1'b1);
    do_reset();
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) seen++;
      step(1'b0, '0, 32'd1, '0, 1'b1);
    end
    check("no_stale", seen, 0);
    single_op(32'd81, 32'd9, 8'h11, lat, res, tg, dbz);
    check("post_reset_lat", lat, 12);
    check("post_reset_res", res, 32'd9);

`ifdef DIV_ZERO_FLAG_EN
    single_op(32'd9, 32'd0, 8'h03, lat, res, tg, dbz);
    check("dbz_res", res, 32'hFFFF_FFFF);
    check("dbz_flag", dbz, 1'b1);
    single_op(32'd9, 32'd3, 8'h04, lat, res, tg, dbz);
    check("nodbz_res", res, 32'd3);
    check("nodbz_flag", dbz, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
